// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Shares one SRAM controller port between the bootloader, the
//             instruction fetch unit (IF) and the data memory stage (MEM).
//             Level-request / one-cycle-done handshake on every side.
//             Boot phase serves only the bootloader; CPU phase serves MEM
//             and IF (fixed MEM-over-IF priority by default).
//  Options  : RAM_ARB_ROUND_ROBIN_EN - alternate between IF and MEM when
//             both request in the same arbitration cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_done,
  input  logic              boot_req,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic [DATA_W-1:0] boot_wdata,
  output logic              boot_ack,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_done,
  output logic [1:0]        owner
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_BOOT = 2'd1;
  localparam logic [1:0] OWN_IF   = 2'd2;
  localparam logic [1:0] OWN_MEM  = 2'd3;

  logic [1:0]        state_q,     state_d;
  logic [1:0]        owner_q,     owner_d;
  logic              ram_req_q,   ram_req_d;
  logic              ram_we_q,    ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              boot_ack_q,  boot_ack_d;
  logic              if_ack_q,    if_ack_d;
  logic              mem_ack_q,   mem_ack_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic gnt_boot;
  logic gnt_if;
  logic gnt_mem;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // 1: MEM wins the next IF/MEM tie, 0: IF wins it
  logic rr_mem_q, rr_mem_d;

  // Grant selection: boot-only in boot phase, alternating tie-break in CPU phase
  always_comb begin
    gnt_boot = 1'b0;
    gnt_if   = 1'b0;
    gnt_mem  = 1'b0;
    if (!boot_done) begin
      gnt_boot = boot_req;
    end else if (if_req && mem_req) begin
      gnt_mem = rr_mem_q;
      gnt_if  = !rr_mem_q;
    end else begin
      gnt_mem = mem_req;
      gnt_if  = if_req;
    end
  end

  // Tie-break pointer moves away from whoever was just granted in IDLE
  always_comb begin
    rr_mem_d = rr_mem_q;
    if (state_q == ST_IDLE) begin
      if (gnt_mem) begin
        rr_mem_d = 1'b0;
      end else if (gnt_if) begin
        rr_mem_d = 1'b1;
      end
    end
  end

  // Pointer register, resets to favour MEM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_mem_q <= 1'b1;
    end else begin
      rr_mem_q <= rr_mem_d;
    end
  end
`else
  // Grant selection: boot-only in boot phase, MEM over IF in CPU phase
  always_comb begin
    gnt_boot = 1'b0;
    gnt_if   = 1'b0;
    gnt_mem  = 1'b0;
    if (!boot_done) begin
      gnt_boot = boot_req;
    end else begin
      gnt_mem = mem_req;
      gnt_if  = if_req && !mem_req;
    end
  end
`endif

  // Next-state logic: IDLE grants and latches, BUSY waits for ram_done, RESP retires
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    boot_ack_d  = 1'b0;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_boot) begin
          state_d     = ST_BUSY;
          owner_d     = OWN_BOOT;
          ram_req_d   = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = boot_addr;
          ram_wdata_d = boot_wdata;
        end else if (gnt_mem) begin
          state_d     = ST_BUSY;
          owner_d     = OWN_MEM;
          ram_req_d   = 1'b1;
          ram_we_d    = mem_we;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
        end else if (gnt_if) begin
          state_d     = ST_BUSY;
          owner_d     = OWN_IF;
          ram_req_d   = 1'b1;
          ram_we_d    = 1'b0;
          ram_addr_d  = if_addr;
          ram_wdata_d = '0;
        end
      end

      ST_BUSY: begin
        // The transaction always completes, even if the requester let go
        if (ram_done) begin
          state_d   = ST_RESP;
          ram_req_d = 1'b0;
          case (owner_q)
            OWN_BOOT: boot_ack_d = 1'b1;
            OWN_IF: begin
              if_ack_d   = 1'b1;
              if_rdata_d = ram_rdata;
            end
            OWN_MEM: begin
              mem_ack_d = 1'b1;
              if (!ram_we_q) begin
                mem_rdata_d = ram_rdata;
              end
            end
            default: ;
          endcase
        end
      end

      ST_RESP: begin
        // Requester drops its level here, so IDLE never sees a stale request
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end

      default: begin
        state_d   = ST_IDLE;
        owner_d   = OWN_NONE;
        ram_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      boot_ack_q  <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      boot_ack_q  <= boot_ack_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign owner     = owner_q;
  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign boot_ack  = boot_ack_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Self-checking bench for ram_arbiter. Requester tasks push the
//             expected RAM access per requester; a RAM-side model checks each
//             grant against those queues and queues the expected response;
//             an ack monitor checks acks and read data against that.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          boot_done, boot_req, boot_ack;
  logic [AW-1:0] boot_addr;
  logic [DW-1:0] boot_wdata;
  logic          if_req, if_ack;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          ram_req, ram_we, ram_done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [1:0]    owner;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .boot_done(boot_done),
    .boot_req(boot_req), .boot_addr(boot_addr), .boot_wdata(boot_wdata), .boot_ack(boot_ack),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_done(ram_done), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; } req_t;
  typedef struct { logic we; logic [DW-1:0] data; } rsp_t;

  req_t       boot_q[$], if_q[$], mem_q[$];
  rsp_t       boot_rq[$], if_rq[$], mem_rq[$];
  logic [1:0] grant_log[$];
  logic       grant_we_log[$];

  int            tests = 0;
  int            fails = 0;
  bit            sb_en = 1'b1;
  int            fixed_lat = -1;
  bit            force_rd = 1'b0;
  logic [DW-1:0] force_val = '0;
  int            boot_acks = 0, if_acks = 0, mem_acks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input string msg);
    tests++;
    fails++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic grant_chk(input string who, input bit have, input req_t e, input req_t c);
    if (!have) begin
      fail_msg({who, "_grant"}, $sformatf("unexpected grant addr=%0h, required no grant", c.addr));
    end else begin
      check({who, "_addr"}, 64'(c.addr), 64'(e.addr));
      check({who, "_we"}, 64'(c.we), 64'(e.we));
      if (e.we) check({who, "_wdata"}, 64'(c.wdata), 64'(e.wdata));
    end
  endtask

  // RAM controller model: logs grants, checks them, responds after a latency
  initial begin : ram_side
    bit busy; int cnt; req_t cap, e; logic [1:0] own; rsp_t r; bit have;
    busy = 1'b0; cnt = 0; ram_done = 1'b0; ram_rdata = '0;
    forever begin
      @(negedge clk);
      ram_done = 1'b0;
      if (!rst || !ram_req) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cap.addr = ram_addr; cap.we = ram_we; cap.wdata = ram_wdata; own = owner;
          cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
          grant_log.push_back(own);
          grant_we_log.push_back(ram_we);
          if (sb_en) begin
            case (own)
              2'd1: begin have = boot_q.size() > 0; if (have) e = boot_q.pop_front(); grant_chk("boot", have, e, cap); end
              2'd2: begin have = if_q.size() > 0;   if (have) e = if_q.pop_front();   grant_chk("if", have, e, cap); end
              2'd3: begin have = mem_q.size() > 0;  if (have) e = mem_q.pop_front();  grant_chk("mem", have, e, cap); end
              default: fail_msg("grant_owner", "ram_req high with owner 0, required nonzero");
            endcase
          end
        end
        if (cnt == 0) begin
          check("ram_hold", {ram_addr, ram_we, ram_wdata}, {cap.addr, cap.we, cap.wdata});
          ram_done  = 1'b1;
          ram_rdata = force_rd ? force_val : DW'($urandom);
          busy      = 1'b0;
          if (sb_en) begin
            r.we = cap.we; r.data = ram_rdata;
            case (own)
              2'd1: boot_rq.push_back(r);
              2'd2: if_rq.push_back(r);
              2'd3: mem_rq.push_back(r);
              default: ;
            endcase
          end
        end else begin
          cnt--;
        end
      end
    end
  end

  // Ack monitor: every ack must match a completed RAM access of that requester
  initial begin : ack_mon
    bit pb, pi, pm; rsp_t r;
    pb = 1'b0; pi = 1'b0; pm = 1'b0;
    forever begin
      @(negedge clk);
      if (boot_ack) begin
        boot_acks++;
        if (sb_en) begin
          check("boot_ack_pulse", 64'(pb), 64'd0);
          if (boot_rq.size() == 0) fail_msg("boot_ack", "unexpected ack, required none");
          else r = boot_rq.pop_front();
        end
      end
      if (if_ack) begin
        if_acks++;
        if (sb_en) begin
          check("if_ack_pulse", 64'(pi), 64'd0);
          if (if_rq.size() == 0) fail_msg("if_ack", "unexpected ack, required none");
          else begin r = if_rq.pop_front(); check("if_rdata", 64'(if_rdata), 64'(r.data)); end
        end
      end
      if (mem_ack) begin
        mem_acks++;
        if (sb_en) begin
          check("mem_ack_pulse", 64'(pm), 64'd0);
          if (mem_rq.size() == 0) fail_msg("mem_ack", "unexpected ack, required none");
          else begin r = mem_rq.pop_front(); if (!r.we) check("mem_rdata", 64'(mem_rdata), 64'(r.data)); end
        end
      end
      pb = boot_ack; pi = if_ack; pm = mem_ack;
    end
  end

  task automatic do_boot(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t e; bit got;
    e.addr = a; e.we = 1'b1; e.wdata = d;
    boot_q.push_back(e);
    boot_addr = a; boot_wdata = d; boot_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); got = boot_ack; end
    boot_req = 1'b0;
    if (!got) fail_msg("boot_timeout", "no boot_ack within 200 cycles, required one");
  endtask

  task automatic do_if(input logic [AW-1:0] a);
    req_t e; bit got;
    e.addr = a; e.we = 1'b0; e.wdata = '0;
    if_q.push_back(e);
    if_addr = a; if_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); got = if_ack; end
    if_req = 1'b0;
    if (!got) fail_msg("if_timeout", "no if_ack within 200 cycles, required one");
  endtask

  task automatic do_mem(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t e; bit got;
    e.addr = a; e.we = we; e.wdata = d;
    mem_q.push_back(e);
    mem_we = we; mem_addr = a; mem_wdata = d; mem_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); got = mem_ack; end
    mem_req = 1'b0;
    if (!got) fail_msg("mem_timeout", "no mem_ack within 200 cycles, required one");
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [1:0] exp_pat [4];
    int hi, ia, ma, n0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp_pat[0] = 2'd3; exp_pat[1] = 2'd2; exp_pat[2] = 2'd3; exp_pat[3] = 2'd2;
`else
    exp_pat[0] = 2'd3; exp_pat[1] = 2'd3; exp_pat[2] = 2'd3; exp_pat[3] = 2'd3;
`endif
    rst = 1'b0; boot_done = 1'b0;
    boot_req = 1'b0; boot_addr = '0; boot_wdata = '0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {ram_req, owner, boot_ack, if_ack, mem_ack, ram_we}, 64'd0);
    check("rst_ram", {ram_addr, ram_wdata}, 64'd0);
    check("rst_rdata", {if_rdata, mem_rdata}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed boot write, RAM done 3 cycles after ram_req rises
    fixed_lat = 2;
    grant_log.delete(); grant_we_log.delete();
    do_boot(18'h00010, 16'h1234);
    check("boot_ack_count", 64'(boot_acks), 64'd1);
    check("boot_grants", 64'(grant_log.size()), 64'd1);
    if (grant_log.size() > 0) check("boot_owner_we", {grant_log[0], grant_we_log[0]}, {2'd1, 1'b1});
    repeat (2) @(negedge clk);
    check("owner_idle", 64'(owner), 64'd0);

    // Boot-phase gating of IF and MEM
    ia = if_acks; ma = mem_acks; hi = 0;
    if_req = 1'b1; mem_req = 1'b1; if_addr = 18'h3; mem_addr = 18'h4;
    repeat (20) begin @(negedge clk); if (ram_req) hi++; end
    check("gate_ram_req", 64'(hi), 64'd0);
    check("gate_acks", 64'(if_acks - ia + mem_acks - ma), 64'd0);

    // Random boot writes while IF/MEM keep requesting (must stay ignored)
    fixed_lat = -1;
    for (int i = 0; i < 15; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_boot(AW'($urandom), DW'($urandom));
    end
    if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);

    // CPU read from IF, data held across an unrelated MEM read
    boot_done = 1'b1;
    fixed_lat = 2; force_rd = 1'b1; force_val = 16'hBEEF;
    grant_log.delete(); grant_we_log.delete();
    do_if(18'h00100);
    force_rd = 1'b0;
    check("if_read_data", 64'(if_rdata), 64'hBEEF);
    if (grant_we_log.size() > 0) check("if_read_we", 64'(grant_we_log[0]), 64'd0);
    repeat (5) @(negedge clk);
    check("if_rdata_hold", 64'(if_rdata), 64'hBEEF);
    do_mem(1'b0, 18'h00200, 16'h0);
    check("if_rdata_hold_mem", 64'(if_rdata), 64'hBEEF);

    // Random concurrent IF and MEM traffic
    fixed_lat = -1;
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_if(AW'($urandom));
      end
      for (int j = 0; j < 25; j++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_mem(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      end
    join

    // Contention from a fresh reset: both held, MEM writes
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb_en = 1'b0; fixed_lat = 1;
    grant_log.delete(); grant_we_log.delete();
    mem_we = 1'b1; mem_addr = 18'h00050; mem_wdata = 16'hCAFE; if_addr = 18'h00060;
    if_req = 1'b1; mem_req = 1'b1;
    for (int i = 0; i < 100 && grant_log.size() < 4; i++) @(negedge clk);
    if_req = 1'b0; mem_req = 1'b0;
    if (grant_log.size() < 4) fail_msg("contention_timeout", "fewer than 4 grants, required 4");
    else for (int k = 0; k < 4; k++) check($sformatf("contention_grant%0d", k), 64'(grant_log[k]), 64'(exp_pat[k]));
    repeat (20) @(negedge clk);
    boot_q.delete(); if_q.delete(); mem_q.delete();
    boot_rq.delete(); if_rq.delete(); mem_rq.delete();
    sb_en = 1'b1;

    // boot_done rises while a boot write is in BUSY
    boot_done = 1'b0; fixed_lat = 4;
    grant_log.delete(); grant_we_log.delete();
    n0 = boot_acks;
    fork
      do_boot(18'h00020, 16'h5555);
      begin
        for (int i = 0; i < 50 && !ram_req; i++) @(negedge clk);
        boot_done = 1'b1;
        do_mem(1'b1, 18'h00030, 16'hAAAA);
      end
    join
    check("edge_boot_ack", 64'(boot_acks - n0), 64'd1);
    check("edge_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) check("edge_order", {grant_log[0], grant_log[1]}, {2'd1, 2'd3});

    // Async reset in the middle of a BUSY IF read
    fixed_lat = 6;
    n0 = if_acks;
    begin
      req_t e;
      e.addr = 18'h00040; e.we = 1'b0; e.wdata = '0;
      if_q.push_back(e);
    end
    if_addr = 18'h00040; if_req = 1'b1;
    for (int i = 0; i < 50 && !ram_req; i++) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ctrl", {ram_req, owner, boot_ack, if_ack, mem_ack}, 64'd0);
    if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("async_rst_no_ack", 64'(if_acks - n0), 64'd0);
    fixed_lat = -1;
    do_if(18'h00041);
    check("post_rst_served", 64'(if_acks - n0), 64'd1);

    repeat (5) @(negedge clk);
    check("sb_drain", 64'(boot_q.size() + if_q.size() + mem_q.size()
                          + boot_rq.size() + if_rq.size() + mem_rq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
